// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: gshare PHT of 2-bit counters plus a tagged,
// direct-mapped BTB, with speculative global history and two-stage training.
module gshare_btb_predictor #(
    parameter int GHR_W = 8,
    parameter int PHT_W = 10,
    parameter int BTB_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    input  logic             if_advance,
    output logic [31:0]      if_pred_pc,
    output logic             if_pred_taken,
    output logic [GHR_W-1:0] if_ghr,
    input  logic             upd_valid,
    input  logic             upd_is_br,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_mispredict,
    output logic             init_done
);

    localparam int PHT_N = 1 << PHT_W;
    localparam int BTB_N = 1 << BTB_W;
    localparam int TAG_W = 32 - BTB_W - 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [PHT_W-1:0]   cnt_q, cnt_d;
    logic [GHR_W-1:0]   ghr_q, ghr_d;
    logic [BTB_N-1:0]   btb_valid_q, btb_valid_d;
    logic               u1_valid_q, u1_valid_d;
    logic               u1_is_br_q, u1_is_br_d;
    logic               u1_taken_q, u1_taken_d;
    logic [PHT_W-1:0]   u1_idx_q, u1_idx_d;
    logic [1:0]         u1_cnt_q, u1_cnt_d;

    logic [1:0]         pht_mem [PHT_N];
    logic [TAG_W-1:0]   btb_tag_mem [BTB_N];
    logic [31:0]        btb_tgt_mem [BTB_N];
    logic               btb_jmp_mem [BTB_N];

    logic               run;
    logic               init_we;
    logic [BTB_W-1:0]   fetch_bidx;
    logic [PHT_W-1:0]   fetch_pidx;
    logic               fetch_hit;
    logic               fetch_jmp;
    logic               fetch_dir;
    logic [PHT_W-1:0]   u0_idx;
    logic [1:0]         u0_cnt;
    logic               u1_we;
    logic [1:0]         u1_wval;
    logic               btb_we;
    logic [BTB_W-1:0]   upd_bidx;
    logic               pht_we;
    logic [PHT_W-1:0]   pht_waddr;
    logic [1:0]         pht_wdata;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == {PHT_W{1'b1}}) begin
            state_d = ST_RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        run       = (state_q == ST_RUN);
        init_we   = (state_q == ST_INIT);
        init_done = (state_q == ST_RUN);
    end

    // Fetch-side prediction, purely combinational from if_pc and current state
    always_comb begin
        fetch_bidx    = if_pc[BTB_W+1:2];
        fetch_pidx    = if_pc[PHT_W+1:2] ^ PHT_W'(ghr_q);
        fetch_hit     = btb_valid_q[fetch_bidx] && (btb_tag_mem[fetch_bidx] == if_pc[31:BTB_W+2]);
        fetch_jmp     = btb_jmp_mem[fetch_bidx];
        fetch_dir     = pht_mem[fetch_pidx][1];
        if_pred_taken = run && fetch_hit && (fetch_jmp || fetch_dir);
        if_pred_pc    = if_pred_taken ? btb_tgt_mem[fetch_bidx] : if_pc + 32'd4;
        if_ghr        = ghr_q;
    end

    // History: speculative shift on conditional hits, repair wins on mispredict
    always_comb begin
        ghr_d = ghr_q;
        if (run) begin
            if (if_advance && fetch_hit && !fetch_jmp) begin
                ghr_d = {ghr_q[GHR_W-2:0], fetch_dir};
            end
            if (upd_valid && upd_mispredict) begin
                ghr_d = upd_is_br ? {upd_ghr[GHR_W-2:0], upd_taken} : upd_ghr;
            end
        end
    end

    // Training: U0 reads (with forwarding from U1), U1 writes the new counter
    always_comb begin
        u1_we = u1_valid_q && u1_is_br_q;
        if (u1_taken_q) begin
            u1_wval = (u1_cnt_q == 2'b11) ? 2'b11 : u1_cnt_q + 2'd1;
        end else begin
            u1_wval = (u1_cnt_q == 2'b00) ? 2'b00 : u1_cnt_q - 2'd1;
        end
        u0_idx = upd_pc[PHT_W+1:2] ^ PHT_W'(upd_ghr);
        u0_cnt = (u1_we && (u1_idx_q == u0_idx)) ? u1_wval : pht_mem[u0_idx];

        u1_valid_d = run && upd_valid;
        u1_is_br_d = upd_is_br;
        u1_taken_d = upd_taken;
        u1_idx_d   = u0_idx;
        u1_cnt_d   = u0_cnt;

        cnt_d     = init_we ? cnt_q + 1'b1 : cnt_q;
        pht_we    = init_we || u1_we;
        pht_waddr = init_we ? cnt_q : u1_idx_q;
        pht_wdata = init_we ? 2'b01 : u1_wval;

        btb_we   = run && upd_valid && upd_taken;
        upd_bidx = upd_pc[BTB_W+1:2];
    end

    generate
        for (genvar gi = 0; gi < BTB_N; gi++) begin : g_btb_valid
            assign btb_valid_d[gi] = btb_valid_q[gi] || (btb_we && (upd_bidx == BTB_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            ghr_q       <= '0;
            btb_valid_q <= '0;
            u1_valid_q  <= 1'b0;
            u1_is_br_q  <= 1'b0;
            u1_taken_q  <= 1'b0;
            u1_idx_q    <= '0;
            u1_cnt_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ghr_q       <= ghr_d;
            btb_valid_q <= btb_valid_d;
            u1_valid_q  <= u1_valid_d;
            u1_is_br_q  <= u1_is_br_d;
            u1_taken_q  <= u1_taken_d;
            u1_idx_q    <= u1_idx_d;
            u1_cnt_q    <= u1_cnt_d;
        end
    end

    // Storage arrays carry no reset; validity lives in btb_valid_q and INIT
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht_mem[pht_waddr] <= pht_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_mem[upd_bidx] <= upd_pc[31:BTB_W+2];
            btb_tgt_mem[upd_bidx] <= upd_target;
            btb_jmp_mem[upd_bidx] <= !upd_is_br;
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Randomised scoreboard bench for gshare_btb_predictor against a
// sequential behavioural model of prediction, history and training.
module tb_gshare_btb_predictor;

    localparam int PN = 1024;
    localparam int BN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_advance;
    logic [31:0] if_pred_pc;
    logic        if_pred_taken;
    logic [7:0]  if_ghr;
    logic        upd_valid;
    logic        upd_is_br;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_ghr;
    logic        upd_mispredict;
    logic        init_done;

    always #5 clk = ~clk;

    gshare_btb_predictor #(.GHR_W(8), .PHT_W(10), .BTB_W(6)) dut (
        .clk(clk), .rst(rst),
        .if_pc(if_pc), .if_advance(if_advance),
        .if_pred_pc(if_pred_pc), .if_pred_taken(if_pred_taken), .if_ghr(if_ghr),
        .upd_valid(upd_valid), .upd_is_br(upd_is_br), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
        .upd_mispredict(upd_mispredict), .init_done(init_done)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_pc;
        logic        exp_tk;
        logic [7:0]  exp_ghr;
        logic        exp_done;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference model state
    logic [7:0]  m_ghr;
    bit          m_run;
    int          m_edges;
    logic [1:0]  pht_vis  [PN];
    logic [1:0]  pht_arch [PN];
    bit          pend_v;
    logic [9:0]  pend_i;
    logic [1:0]  pend_c;
    bit          b_valid [BN];
    logic [31:0] b_pc    [BN];
    logic [31:0] b_tgt   [BN];
    bit          b_jmp   [BN];

    logic [31:0] pool [8] = '{32'h0000_0200, 32'h0000_0300, 32'h0000_1300, 32'h0000_2340,
                              32'hFFFF_FFFC, 32'h0000_0080, 32'h0000_0404, 32'h0000_07F0};

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    function automatic void model_reset();
        m_ghr   = '0;
        m_run   = 1'b0;
        m_edges = 0;
        pend_v  = 1'b0;
        for (int i = 0; i < BN; i++) b_valid[i] = 1'b0;
    endfunction

    task automatic step(input logic r, input logic [31:0] pc, input logic adv,
                        input logic uv, input logic ubr, input logic [31:0] upc,
                        input logic utk, input logic [31:0] utgt,
                        input logic [7:0] ughr, input logic umis);
        exp_t       e;
        logic [5:0] bi;
        logic [9:0] pi;
        logic [9:0] ui;
        logic [1:0] c;
        logic [7:0] g;
        logic       hit;
        logic       tk;
        @(posedge clk);
        #1;
        rst = r; if_pc = pc; if_advance = adv;
        upd_valid = uv; upd_is_br = ubr; upd_pc = upc; upd_taken = utk;
        upd_target = utgt; upd_ghr = ughr; upd_mispredict = umis;
        if (!r) model_reset();
        bi  = pc[7:2];
        pi  = pc[11:2] ^ {2'b00, m_ghr};
        hit = b_valid[bi] && (b_pc[bi][31:2] == pc[31:2]);
        tk  = m_run && hit && (b_jmp[bi] || pht_vis[pi][1]);
        e.pc       = pc;
        e.exp_tk   = tk;
        e.exp_pc   = tk ? b_tgt[bi] : pc + 32'd4;
        e.exp_ghr  = m_ghr;
        e.exp_done = m_run;
        sbq.push_back(e);
        // Effect of the coming clock edge
        if (r) begin
            if (!m_run) begin
                m_edges++;
                if (m_edges == PN) begin
                    m_run = 1'b1;
                    for (int i = 0; i < PN; i++) begin
                        pht_vis[i]  = 2'b01;
                        pht_arch[i] = 2'b01;
                    end
                end
            end else begin
                if (pend_v) pht_vis[pend_i] = pend_c;
                pend_v = 1'b0;
                g = m_ghr;
                if (adv && hit && !b_jmp[bi]) g = {m_ghr[6:0], tk};
                if (uv && umis) g = ubr ? {ughr[6:0], utk} : ughr;
                if (uv && ubr) begin
                    ui = upc[11:2] ^ {2'b00, ughr};
                    c  = sat2(pht_arch[ui], utk);
                    pht_arch[ui] = c;
                    pend_v = 1'b1; pend_i = ui; pend_c = c;
                end
                if (uv && utk) begin
                    b_valid[upc[7:2]] = 1'b1;
                    b_pc[upc[7:2]]    = upc;
                    b_tgt[upc[7:2]]   = utgt;
                    b_jmp[upc[7:2]]   = !ubr;
                end
                m_ghr = g;
            end
        end
    endtask

    task automatic idle(input logic [31:0] pc, input logic adv);
        step(1'b1, pc, adv, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic adv, input logic ubr,
                       input logic [31:0] upc, input logic utk, input logic [31:0] utgt,
                       input logic [7:0] ughr, input logic umis);
        step(1'b1, pc, adv, 1'b1, ubr, upc, utk, utgt, ughr, umis);
    endtask

    // Monitor: pops one expectation per sampled cycle, away from the active edge
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                me = sbq.pop_front();
                txn++;
                $display("txn %0d pc=%h pred_pc=%h taken=%b ghr=%h init_done=%b",
                         txn, me.pc, if_pred_pc, if_pred_taken, if_ghr, init_done);
                total++;
                if (if_pred_pc !== me.exp_pc) begin
                    bad++;
                    $display("FAIL pred_pc txn=%0d got=%h exp=%h", txn, if_pred_pc, me.exp_pc);
                end
                total++;
                if (if_pred_taken !== me.exp_tk) begin
                    bad++;
                    $display("FAIL pred_taken txn=%0d got=%b exp=%b", txn, if_pred_taken, me.exp_tk);
                end
                total++;
                if (if_ghr !== me.exp_ghr) begin
                    bad++;
                    $display("FAIL ghr txn=%0d got=%h exp=%h", txn, if_ghr, me.exp_ghr);
                end
                total++;
                if (init_done !== me.exp_done) begin
                    bad++;
                    $display("FAIL init_done txn=%0d got=%b exp=%b", txn, init_done, me.exp_done);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        logic [31:0] rupc;
        logic        rbr;
        rst = 1'b0; if_pc = 32'h100; if_advance = 1'b0;
        upd_valid = 1'b0; upd_is_br = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_ghr = '0; upd_mispredict = 1'b0;

        // Reset, then INIT with an ignored update to 0x100
        repeat (3) step(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
        for (int i = 0; i < 1030; i++) begin
            if (i == 10) upd(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h500, 8'h33, 1'b1);
            else         idle(32'h100, 1'b1);
        end
        idle(32'hFFFF_FFFC, 1'b1);

        // Jump trained, then fetched
        upd(32'h0, 1'b0, 1'b0, 32'h200, 1'b1, 32'h400, 8'h00, 1'b0);
        idle(32'h200, 1'b1);
        idle(32'h200, 1'b0);

        // Two taken branch updates accumulate via forwarding
        upd(32'h0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h340, 8'h00, 1'b0);
        upd(32'h0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h340, 8'h00, 1'b0);
        idle(32'h0, 1'b0);
        idle(32'h300, 1'b1);
        idle(32'h300, 1'b0);

        // Three not-taken updates; the last repairs history back to 0
        upd(32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 8'h00, 1'b0);
        upd(32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 8'h00, 1'b0);
        upd(32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 8'h00, 1'b1);
        idle(32'h0, 1'b0);
        idle(32'h300, 1'b1);
        idle(32'h300, 1'b0);

        // History at 0x5A, then repair racing a speculative shift
        upd(32'h0, 1'b0, 1'b0, 32'h200, 1'b1, 32'h400, 8'h5A, 1'b1);
        upd(32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 32'h340, 8'h10, 1'b1);
        idle(32'h300, 1'b0);

        // Randomised traffic over a small PC pool with deliberate BTB conflicts
        for (int i = 0; i < 2000; i++) begin
            rpc  = pool[$urandom_range(0, 7)];
            rupc = pool[$urandom_range(0, 7)];
            rbr  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                upd(rpc, 1'($urandom_range(0, 1)), rbr, rupc,
                    rbr ? 1'($urandom_range(0, 1)) : 1'b1,
                    $urandom() & 32'hFFFF_FFFC, 8'($urandom()),
                    ($urandom_range(0, 3) == 0));
            else
                idle(rpc, 1'($urandom_range(0, 1)));
        end

        // Reset mid-INIT, then a full INIT; BTB must be empty afterwards
        repeat (2) step(1'b0, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0);
        for (int i = 0; i < 500; i++) idle(32'h300, 1'b1);
        repeat (2) step(1'b0, 32'h300, 1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 32'h0, 8'h00, 1'b1);
        for (int i = 0; i < 1030; i++) idle(32'h200, 1'b1);
        for (int i = 0; i < 8; i++) idle(pool[i], 1'b1);

        repeat (3) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
